// File: rtl/multi_channel_strobe_counter_if.sv
// Bundle of per-channel tick, configuration and status signals for the
// multi-channel strobe counter.
interface multi_channel_strobe_counter_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
);
  localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] enable;
  logic [CHANNELS-1:0] rearm;
  logic                cfg_we;
  logic [CH_BITS-1:0]  cfg_ch;
  logic [WIDTH-1:0]    cfg_period;
  logic                cfg_oneshot;
  logic [CHANNELS-1:0] pend_clr;
  logic [CHANNELS-1:0] strobe;
  logic [CHANNELS-1:0] armed;
  logic [CHANNELS-1:0] pending;
  logic                irq;

  modport master (
    output enable, rearm, cfg_we, cfg_ch, cfg_period, cfg_oneshot, pend_clr,
    input  strobe, armed, pending, irq
  );

  modport slave (
    input  enable, rearm, cfg_we, cfg_ch, cfg_period, cfg_oneshot, pend_clr,
    output strobe, armed, pending, irq
  );
endinterface

// File: rtl/multi_channel_strobe_counter.sv
// CHANNELS independent tick counters with programmable period, one-shot or
// periodic mode, rearm, sticky pending flags and a registered irq.
module multi_channel_strobe_counter #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
) (
  input  logic clk,
  input  logic rst,
  multi_channel_strobe_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0]    count_q  [CHANNELS];
  logic [WIDTH-1:0]    count_d  [CHANNELS];
  logic [WIDTH-1:0]    period_q [CHANNELS];
  logic [WIDTH-1:0]    period_d [CHANNELS];
  logic [CHANNELS-1:0] oneshot_q, oneshot_d;
  logic [CHANNELS-1:0] armed_q, armed_d;
  logic [CHANNELS-1:0] strobe_q, strobe_d;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [CHANNELS-1:0] cfg_sel;
  logic                irq_q;

  // Priority per channel: cfg write > rearm > enable; the loser's tick is dropped.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cfg_sel[i]   = bus.cfg_we && (int'(bus.cfg_ch) == i);
      count_d[i]   = count_q[i];
      period_d[i]  = period_q[i];
      oneshot_d[i] = oneshot_q[i];
      armed_d[i]   = armed_q[i];
      strobe_d[i]  = 1'b0;
      if (cfg_sel[i]) begin
        period_d[i]  = bus.cfg_period;
        oneshot_d[i] = bus.cfg_oneshot;
        count_d[i]   = ONE;
        armed_d[i]   = 1'b1;
      end else if (bus.rearm[i]) begin
        count_d[i] = ONE;
        armed_d[i] = 1'b1;
      end else if (armed_q[i] && bus.enable[i] && (period_q[i] != '0)) begin
        if (count_q[i] == period_q[i]) begin
          strobe_d[i] = 1'b1;
          count_d[i]  = ONE;
          if (oneshot_q[i]) armed_d[i] = 1'b0;
        end else begin
          count_d[i] = count_q[i] + ONE;
        end
      end
      pending_d[i] = strobe_d[i] | (pending_q[i] & ~bus.pend_clr[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        count_q[i]  <= ONE;
        period_q[i] <= '0;
      end
      oneshot_q <= '0;
      armed_q   <= '0;
      strobe_q  <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        count_q[i]  <= count_d[i];
        period_q[i] <= period_d[i];
      end
      oneshot_q <= oneshot_d;
      armed_q   <= armed_d;
      strobe_q  <= strobe_d;
      pending_q <= pending_d;
      irq_q     <= |pending_q;
    end
  end

  assign bus.strobe  = strobe_q;
  assign bus.armed   = armed_q;
  assign bus.pending = pending_q;
  assign bus.irq     = irq_q;
endmodule

// File: tb/tb_multi_channel_strobe_counter.sv
// Directed bench: a 4-channel 8-bit instance for function and boundaries,
// plus a 3-channel instance for the unused channel index.
module tb_multi_channel_strobe_counter;
  logic clk;
  logic rst;
  int   checks;
  int   passed;

  multi_channel_strobe_counter_if #(.CHANNELS(4), .WIDTH(8)) bus ();
  multi_channel_strobe_counter_if #(.CHANNELS(3), .WIDTH(8)) bus3 ();

  multi_channel_strobe_counter #(.CHANNELS(4), .WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  multi_channel_strobe_counter #(.CHANNELS(3), .WIDTH(8)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.enable = '0; bus.rearm = '0; bus.cfg_we = 1'b0; bus.cfg_ch = '0;
    bus.cfg_period = '0; bus.cfg_oneshot = 1'b0; bus.pend_clr = '0;
    bus3.enable = '0; bus3.rearm = '0; bus3.cfg_we = 1'b0; bus3.cfg_ch = '0;
    bus3.cfg_period = '0; bus3.cfg_oneshot = 1'b0; bus3.pend_clr = '0;
  endtask

  task automatic cfg(input int ch, input int p, input bit os);
    bus.cfg_we = 1'b1; bus.cfg_ch = 2'(ch); bus.cfg_period = 8'(p);
    bus.cfg_oneshot = os;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick(); tick();
    rst = 1'b0;
    checks++; if (bus.strobe !== 4'b0) $display("FAIL reset_strobe got=%b exp=0000", bus.strobe); else passed++;
    checks++; if (bus.armed !== 4'b0) $display("FAIL reset_armed got=%b exp=0000", bus.armed); else passed++;
    checks++; if (bus.pending !== 4'b0) $display("FAIL reset_pending got=%b exp=0000", bus.pending); else passed++;
    checks++; if (bus.irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", bus.irq); else passed++;
    checks++; if (bus3.armed !== 3'b0) $display("FAIL reset_armed3 got=%b exp=000", bus3.armed); else passed++;
  endtask

  task automatic test_periodic();
    cfg(0, 3, 1'b0);
    checks++; if (bus.armed !== 4'b0001) $display("FAIL periodic_armed got=%b exp=0001", bus.armed); else passed++;
    bus.enable[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (bus.strobe[0] !== ((k % 3) == 0)) $display("FAIL periodic_strobe k=%0d got=%b exp=%b", k, bus.strobe[0], (k % 3) == 0);
      else passed++;
      if (k == 3) begin
        checks++; if (bus.pending[0] !== 1'b1) $display("FAIL periodic_pending got=%b exp=1", bus.pending[0]); else passed++;
        checks++; if (bus.irq !== 1'b0) $display("FAIL periodic_irq_lag got=%b exp=0", bus.irq); else passed++;
      end
      if (k == 4) begin
        checks++; if (bus.irq !== 1'b1) $display("FAIL periodic_irq got=%b exp=1", bus.irq); else passed++;
      end
    end
    checks++; if (bus.armed[0] !== 1'b1) $display("FAIL periodic_stay_armed got=%b exp=1", bus.armed[0]); else passed++;
    // Pending is still set; a clear coinciding with a new expiry must lose.
    tick(); tick();
    bus.pend_clr[0] = 1'b1;
    tick();
    bus.enable[0] = 1'b0;
    checks++; if (bus.strobe[0] !== 1'b1) $display("FAIL clr_collision_strobe got=%b exp=1", bus.strobe[0]); else passed++;
    checks++; if (bus.pending[0] !== 1'b1) $display("FAIL clr_collision_pending got=%b exp=1", bus.pending[0]); else passed++;
    tick();
    bus.pend_clr[0] = 1'b0;
    checks++; if (bus.pending[0] !== 1'b0) $display("FAIL pend_clear got=%b exp=0", bus.pending[0]); else passed++;
    tick();
    checks++; if (bus.irq !== 1'b0) $display("FAIL irq_clear got=%b exp=0", bus.irq); else passed++;
  endtask

  task automatic test_oneshot();
    cfg(1, 2, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      bus.enable[1] = (k % 2) == 1;
      tick();
      checks++;
      if (bus.strobe[1] !== (k == 3)) $display("FAIL oneshot_strobe k=%0d got=%b exp=%b", k, bus.strobe[1], k == 3);
      else passed++;
      checks++;
      if (bus.armed[1] !== (k < 3)) $display("FAIL oneshot_armed k=%0d got=%b exp=%b", k, bus.armed[1], k < 3);
      else passed++;
    end
    bus.enable[1] = 1'b0;
    bus.rearm[1] = 1'b1;
    tick();
    bus.rearm[1] = 1'b0;
    checks++; if (bus.armed[1] !== 1'b1) $display("FAIL rearm_armed got=%b exp=1", bus.armed[1]); else passed++;
    bus.enable[1] = 1'b1;
    tick();
    checks++; if (bus.strobe[1] !== 1'b0) $display("FAIL rearm_tick1 got=%b exp=0", bus.strobe[1]); else passed++;
    tick();
    bus.enable[1] = 1'b0;
    checks++; if (bus.strobe[1] !== 1'b1) $display("FAIL rearm_tick2 got=%b exp=1", bus.strobe[1]); else passed++;
    tick();
    checks++; if (bus.armed[1] !== 1'b0) $display("FAIL rearm_disarm got=%b exp=0", bus.armed[1]); else passed++;
    bus.pend_clr = 4'b1111;
    tick();
    bus.pend_clr = '0;
  endtask

  task automatic test_boundaries();
    int n;
    cfg(3, 1, 1'b0);
    bus.enable[3] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++; if (bus.strobe[3] !== 1'b1) $display("FAIL p1_strobe k=%0d got=%b exp=1", k, bus.strobe[3]); else passed++;
    end
    bus.enable[3] = 1'b0;
    tick();
    checks++; if (bus.strobe[3] !== 1'b0) $display("FAIL p1_idle got=%b exp=0", bus.strobe[3]); else passed++;

    cfg(2, 0, 1'b0);
    bus.enable[2] = 1'b1;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.strobe[2] === 1'b1) n++;
    end
    bus.enable[2] = 1'b0;
    checks++; if (n !== 0) $display("FAIL p0_strobes got=%0d exp=0", n); else passed++;
    checks++; if (bus.armed[2] !== 1'b1) $display("FAIL p0_armed got=%b exp=1", bus.armed[2]); else passed++;

    cfg(2, 255, 1'b0);
    bus.enable[2] = 1'b1;
    n = 0;
    for (int k = 1; k <= 254; k++) begin
      tick();
      if (bus.strobe[2] === 1'b1) n++;
    end
    checks++; if (n !== 0) $display("FAIL p255_early got=%0d exp=0", n); else passed++;
    tick();
    checks++; if (bus.strobe[2] !== 1'b1) $display("FAIL p255_tick255 got=%b exp=1", bus.strobe[2]); else passed++;
    tick();
    bus.enable[2] = 1'b0;
    checks++; if (bus.strobe[2] !== 1'b0) $display("FAIL p255_after got=%b exp=0", bus.strobe[2]); else passed++;
  endtask

  task automatic test_cfg_collision();
    cfg(2, 2, 1'b0);
    bus.enable[2] = 1'b1;
    tick();
    bus.cfg_we = 1'b1; bus.cfg_ch = 2'd2; bus.cfg_period = 8'd2; bus.cfg_oneshot = 1'b0;
    tick();
    bus.cfg_we = 1'b0;
    checks++; if (bus.strobe[2] !== 1'b0) $display("FAIL cfg_collision_strobe got=%b exp=0", bus.strobe[2]); else passed++;
    tick();
    checks++; if (bus.strobe[2] !== 1'b0) $display("FAIL cfg_collision_count1 got=%b exp=0", bus.strobe[2]); else passed++;
    tick();
    bus.enable[2] = 1'b0;
    checks++; if (bus.strobe[2] !== 1'b1) $display("FAIL cfg_collision_count2 got=%b exp=1", bus.strobe[2]); else passed++;
    bus.pend_clr = 4'b1111;
    tick();
    bus.pend_clr = '0;
  endtask

  task automatic test_independence();
    int ticks [4];
    int seen  [4];
    int per   [4];
    per[0] = 2; per[1] = 3; per[2] = 5; per[3] = 7;
    for (int c = 0; c < 4; c++) begin
      cfg(c, per[c], 1'b0);
      ticks[c] = 0;
      seen[c]  = 0;
    end
    for (int k = 0; k < 120; k++) begin
      bus.enable = 4'($urandom_range(0, 15));
      for (int c = 0; c < 4; c++) if (bus.enable[c]) ticks[c]++;
      tick();
      for (int c = 0; c < 4; c++) if (bus.strobe[c] === 1'b1) seen[c]++;
    end
    bus.enable = '0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (seen[c] !== ticks[c] / per[c]) $display("FAIL indep_ch%0d got=%0d exp=%0d", c, seen[c], ticks[c] / per[c]);
      else passed++;
    end

    // Reset lands on the edge where channel 0 would expire again.
    cfg(0, 1, 1'b0);
    bus.enable = 4'b1111;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.enable = '0;
    checks++; if (bus.strobe !== 4'b0) $display("FAIL midreset_strobe got=%b exp=0000", bus.strobe); else passed++;
    checks++; if (bus.armed !== 4'b0) $display("FAIL midreset_armed got=%b exp=0000", bus.armed); else passed++;
    checks++; if (bus.pending !== 4'b0) $display("FAIL midreset_pending got=%b exp=0000", bus.pending); else passed++;
    checks++; if (bus.irq !== 1'b0) $display("FAIL midreset_irq got=%b exp=0", bus.irq); else passed++;
  endtask

  task automatic test_out_of_range();
    bus3.cfg_we = 1'b1; bus3.cfg_ch = 2'd0; bus3.cfg_period = 8'd2; bus3.cfg_oneshot = 1'b0;
    tick();
    bus3.cfg_ch = 2'd3; bus3.cfg_period = 8'd1; bus3.cfg_oneshot = 1'b1;
    tick();
    bus3.cfg_we = 1'b0;
    checks++; if (bus3.armed !== 3'b001) $display("FAIL oor_armed got=%b exp=001", bus3.armed); else passed++;
    bus3.enable = 3'b111;
    tick();
    checks++; if (bus3.strobe !== 3'b000) $display("FAIL oor_tick1 got=%b exp=000", bus3.strobe); else passed++;
    tick();
    bus3.enable = 3'b000;
    checks++; if (bus3.strobe !== 3'b001) $display("FAIL oor_tick2 got=%b exp=001", bus3.strobe); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b1;
    idle();
    test_reset();
    test_periodic();
    test_oneshot();
    test_boundaries();
    test_cfg_collision();
    test_independence();
    test_out_of_range();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/multi_channel_strobe_counter.md
Name: multi_channel_strobe_counter

Overview:
- Multi-channel generalisation of the single-channel strobe counter.
- Provides CHANNELS independent tick counters. Each channel has a runtime-programmable period, periodic or one-shot mode, per-channel rearm, and a sticky pending flag with write-1-to-clear.
- Sits between timebase/prescaler logic (drives enable ticks) and interrupt/sequencing logic (consumes strobes, pending, irq).

Parameters:
- CHANNELS, 4, number of independent counter channels (1..32).
- WIDTH, 16, counter and period width in bits (2..32).
- CH_BITS, $clog2(CHANNELS) (min 1), width of channel index; derived, not overridden.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- enable  input  CHANNELS  per-channel count tick; bit i counts channel i.
- rearm  input  CHANNELS  per-channel restart: count:=1, armed:=1.
- cfg_we  input  1  configuration write strobe.
- cfg_ch  input  CH_BITS  channel index for cfg write.
- cfg_period  input  WIDTH  period P for the addressed channel.
- cfg_oneshot  input  1  1 = one-shot mode, 0 = periodic.
- pend_clr  input  CHANNELS  write-1-to-clear for pending bits.
- strobe  output  CHANNELS  one-cycle pulse per expiry.
- armed  output  CHANNELS  channel is counting.
- pending  output  CHANNELS  sticky expiry flags.
- irq  output  1  registered OR of pending.

Behaviour:
- Per-channel state: count[WIDTH], period[WIDTH], oneshot, armed, pending, strobe register.
- Reset (synchronous): count=1, period=0, oneshot=0, armed=0, strobe=0, pending=0, irq=0. All outputs are registered.
- Counting, channel i, armed=1, P>=1:
  - enable[i]=1 and count==P: strobe[i]=1 next cycle; count:=1.
  - enable[i]=1 and count!=P: count:=count+1.
  - enable[i]=0: count holds; strobe[i]=0 next cycle.
- Strobe timing:
  - Strobe is asserted in the cycle after the P-th accepted tick (1-cycle latency).
  - Strobe never stays high two consecutive cycles unless P==1 with enable held high. In that case strobe is high every cycle following a tick.
- P==0: channel never strobes and count holds at 1, even when armed.
- Mode:
  - Periodic: armed stays 1 after expiry.
  - One-shot: expiry clears armed next cycle, together with the strobe. Further enables are ignored until rearm or a cfg write.
- armed=0: enable is ignored and count holds.
- cfg_we=1:
  - channel[cfg_ch] gets period:=cfg_period, oneshot:=cfg_oneshot, count:=1, armed:=1, effective next cycle.
  - cfg_ch>=CHANNELS: write ignored.
- rearm[i]=1: count:=1, armed:=1. Period and mode are unchanged.
- Priority for a channel in one cycle: rst > cfg write > rearm > enable. A lower-priority enable that cycle is discarded and produces no strobe.
- Pending: pending[i] sets on the same edge strobe[i] is registered high. pend_clr[i]=1 clears it. If set and clear coincide, set wins.
- irq = registered OR of pending, so it lags pending by one cycle.
- Counter width: count never exceeds P, so no wrap occurs. P=2^WIDTH-1 is legal and gives the maximum period.
- Reset mid-count: all state returns to reset values on the next edge. A strobe that would have fired is suppressed.

Test Plan:
- Periodic: cfg ch0 P=3 periodic, enable[0] high continuously -> strobe[0] high on cycles 3,6,9 after the first tick cycle; pending[0]=1, irq=1 one cycle later.
- One-shot: cfg ch1 P=2 oneshot, enable[1] on alternate cycles -> exactly one strobe[1] after the 2nd tick, armed[1]=0; further ticks give no strobe. rearm[1] then 2 ticks -> one more strobe.
- Boundaries: P=1 with enable held high -> strobe every cycle. P=0 -> no strobe across 20 ticks. P=255 (WIDTH=8) -> strobe after tick 255 exactly.
- Collisions: cfg write to ch2 coinciding with enable[2] and count==P -> no strobe, count=1. pend_clr[0] in the same cycle as a new ch0 expiry -> pending[0] stays 1.
- Independence/reset: 4 channels with P=2,3,5,7 under random enables -> each strobe count equals floor(ticks/P). Assert rst mid-run -> all outputs 0 next cycle, armed=0.
- Out-of-range index: CHANNELS=3, cfg_ch=3 write -> no channel state changes.
